// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and the
// arithmetic helpers used by mdu_unit.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 8;

  // Full 64-bit product; operands are sign- or zero-extended to 66 bits first.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [65:0] ax;
    logic signed [65:0] bx;
    logic signed [65:0] p;
    ax = $signed({{34{sgn & a[31]}}, a});
    bx = $signed({{34{sgn & b[31]}}, b});
    p  = ax * bx;
    return p[63:0];
  endfunction

  // Returns {remainder, quotient}. Magnitude division keeps the
  // 0x80000000 / -1 overflow case well defined (quotient wraps to 0x80000000).
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;
    a_mag = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag = (sgn && b[31]) ? (~b + 32'd1) : b;
    q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    q     = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    r     = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage <-> MDU signal bundle; master is the pipeline side, slave the MDU.
interface mdu_unit_if;
  import mdu_unit_pkg::*;

  mdu_op_e     MDUOp;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic        E_Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_Out;

  modport master (output MDUOp, Start, A, B, Req,
                  input  Busy, E_Busy, HI, LO, MDU_Out);
  modport slave  (input  MDUOp, Start, A, B, Req,
                  output Busy, E_Busy, HI, LO, MDU_Out);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_MADD_EN to add
// the MADD/MADDU/MSUB/MSUBU accumulate operations.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic         clk,
  input logic         reset,
  mdu_unit_if.slave   mdu
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       temp_hi_q, temp_hi_d;
  logic [31:0]       temp_lo_q, temp_lo_d;
  logic              commit_q, commit_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      commit_q  <= commit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    commit_d  = commit_q;

    case (state_q)
      ST_IDLE: begin
        // A request in this cycle blocks every kind of commit.
        if (!mdu.Req) begin
          if (mdu.Start) begin
            case (mdu.MDUOp)
              MDU_MULT, MDU_MULTU: begin
                {temp_hi_d, temp_lo_d} = mul64(mdu.A, mdu.B, mdu.MDUOp == MDU_MULT);
                cnt_d    = CNT_W'(MULT_CYCLES);
                commit_d = 1'b1;
                state_d  = ST_BUSY;
              end
              MDU_DIV, MDU_DIVU: begin
                {temp_hi_d, temp_lo_d} = div64(mdu.A, mdu.B, mdu.MDUOp == MDU_DIV);
                cnt_d    = CNT_W'(DIV_CYCLES);
                commit_d = (mdu.B != 32'd0);
                state_d  = ST_BUSY;
              end
`ifdef MDU_MADD_EN
              MDU_MADD, MDU_MADDU: begin
                {temp_hi_d, temp_lo_d} = {hi_q, lo_q} + mul64(mdu.A, mdu.B, mdu.MDUOp == MDU_MADD);
                cnt_d    = CNT_W'(MULT_CYCLES);
                commit_d = 1'b1;
                state_d  = ST_BUSY;
              end
              MDU_MSUB, MDU_MSUBU: begin
                {temp_hi_d, temp_lo_d} = {hi_q, lo_q} - mul64(mdu.A, mdu.B, mdu.MDUOp == MDU_MSUB);
                cnt_d    = CNT_W'(MULT_CYCLES);
                commit_d = 1'b1;
                state_d  = ST_BUSY;
              end
`endif
              default: ;
            endcase
          end else if (mdu.MDUOp == MDU_MTHI) begin
            hi_d = mdu.A;
          end else if (mdu.MDUOp == MDU_MTLO) begin
            lo_d = mdu.A;
          end
        end
      end
      ST_BUSY: begin
        // Already committed: Req and Start are both ignored until completion.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (commit_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mdu.Busy    = (state_q == ST_BUSY);
  assign mdu.E_Busy  = mdu.Start | mdu.Busy;
  assign mdu.HI      = hi_q;
  assign mdu.LO      = lo_q;
  assign mdu.MDU_Out = (mdu.MDUOp == MDU_MFHI) ? hi_q :
                       (mdu.MDUOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit; expected values are hand-computed.
`timescale 1ns/1ps
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_unit_if mdu ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Start while busy must never be driven by this bench.
  always @(negedge clk)
    if (reset && mdu.Start && mdu.Busy) check_val("start_in_busy", 32'd1, 32'd0);

  // Present a Start op for one cycle; returns at the negedge after the start edge.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    @(negedge clk);
    mdu.MDUOp = op;
    mdu.Start = 1'b1;
    mdu.A     = a;
    mdu.B     = b;
    mdu.Req   = req;
    @(negedge clk);
    mdu.MDUOp = MDU_NOP;
    mdu.Start = 1'b0;
    mdu.Req   = 1'b0;
  endtask

  task automatic move_to(input mdu_op_e op, input logic [31:0] a, input logic req);
    @(negedge clk);
    mdu.MDUOp = op;
    mdu.A     = a;
    mdu.Req   = req;
    @(negedge clk);
    mdu.MDUOp = MDU_NOP;
    mdu.Req   = 1'b0;
  endtask

  // Counts negedges with Busy high; bounded so a stuck Busy cannot hang.
  task automatic wait_idle(output int n);
    n = 0;
    while (mdu.Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_out(input mdu_op_e op, output logic [31:0] v);
    mdu.MDUOp = op;
    #1;
    v = mdu.MDU_Out;
    mdu.MDUOp = MDU_NOP;
  endtask

  initial begin
    int          n;
    logic [31:0] v;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    mdu.MDUOp = MDU_NOP;
    mdu.Start = 1'b0;
    mdu.A     = '0;
    mdu.B     = '0;
    mdu.Req   = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'd0, mdu.Busy}, 32'd0);
    check_val("rst_hi", mdu.HI, 32'd0);
    check_val("rst_lo", mdu.LO, 32'd0);
    reset = 1'b1;

    // MULT -2 * 3; E_Busy must already be high in the Start cycle.
    @(negedge clk);
    mdu.MDUOp = MDU_MULT; mdu.Start = 1'b1; mdu.A = 32'hFFFF_FFFE; mdu.B = 32'd3;
    #1;
    check_val("ebusy_start", {31'd0, mdu.E_Busy}, 32'd1);
    @(negedge clk);
    mdu.MDUOp = MDU_NOP; mdu.Start = 1'b0;
    wait_idle(n);
    check_val("mult_cycles", 32'(n), 32'd5);
    check_val("mult_hi", mdu.HI, 32'hFFFF_FFFF);
    check_val("mult_lo", mdu.LO, 32'hFFFF_FFFA);
    read_out(MDU_MFHI, v);
    check_val("mfhi_out", v, 32'hFFFF_FFFF);
    read_out(MDU_MFLO, v);
    check_val("mflo_out", v, 32'hFFFF_FFFA);
    read_out(MDU_NOP, v);
    check_val("nop_out", v, 32'd0);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    check_val("div_cycles", 32'(n), 32'd10);
    check_val("div_lo", mdu.LO, 32'hFFFF_FFFD);
    check_val("div_hi", mdu.HI, 32'hFFFF_FFFF);

    issue(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle(n);
    check_val("divu_lo", mdu.LO, 32'd3);
    check_val("divu_hi", mdu.HI, 32'd1);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    check_val("divovf_lo", mdu.LO, 32'h8000_0000);
    check_val("divovf_hi", mdu.HI, 32'd0);

    move_to(MDU_MTHI, 32'h11, 1'b0);
    check_val("mthi_busy", {31'd0, mdu.Busy}, 32'd0);
    move_to(MDU_MTLO, 32'h22, 1'b0);
    check_val("mthi_hi", mdu.HI, 32'h11);
    check_val("mtlo_lo", mdu.LO, 32'h22);
    move_to(MDU_MTHI, 32'h99, 1'b1);
    check_val("mthi_req_hi", mdu.HI, 32'h11);

    issue(MDU_DIV, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    check_val("div0_cycles", 32'(n), 32'd10);
    check_val("div0_hi", mdu.HI, 32'h11);
    check_val("div0_lo", mdu.LO, 32'h22);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_val("req_start_busy", {31'd0, mdu.Busy}, 32'd0);
    @(negedge clk);
    check_val("req_start_hi", mdu.HI, 32'h11);
    check_val("req_start_lo", mdu.LO, 32'h22);

    // Req raised in the third busy cycle must not cancel the op.
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(negedge clk);
    mdu.Req = 1'b1;
    @(negedge clk);
    mdu.Req = 1'b0;
    wait_idle(n);
    check_val("req_busy_tail", 32'(n), 32'd2);
    check_val("req_busy_hi", mdu.HI, 32'hFFFF_FFFE);
    check_val("req_busy_lo", mdu.LO, 32'h0000_0001);

    // Async reset in the middle of a divide.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, mdu.Busy}, 32'd0);
    check_val("midrst_hi", mdu.HI, 32'd0);
    check_val("midrst_lo", mdu.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(MDU_MULT, 32'd6, 32'd7, 1'b0);
    wait_idle(n);
    check_val("postrst_lo", mdu.LO, 32'd42);
    check_val("postrst_hi", mdu.HI, 32'd0);

    move_to(MDU_MTHI, 32'd0, 1'b0);
    move_to(MDU_MTLO, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_MADD_EN
    issue(MDU_MADDU, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
    check_val("maddu_cycles", 32'(n), 32'd5);
    check_val("maddu_hi", mdu.HI, 32'd1);
    check_val("maddu_lo", mdu.LO, 32'd0);
    issue(MDU_MSUB, 32'd2, 32'd3, 1'b0);
    wait_idle(n);
    check_val("msub_hi", mdu.HI, 32'd0);
    check_val("msub_lo", mdu.LO, 32'hFFFF_FFFA);
`else
    issue(MDU_MADDU, 32'd1, 32'd1, 1'b0);
    check_val("maddu_nop_busy", {31'd0, mdu.Busy}, 32'd0);
    @(negedge clk);
    check_val("maddu_nop_hi", mdu.HI, 32'd0);
    check_val("maddu_nop_lo", mdu.LO, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
